byte_fifo: RTL and testbench



---
 rtl/byte_fifo.sv | 58 +++++
 tb/tb_byte_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/byte_fifo.sv
// Small synchronous first-word-fall-through FIFO that buffers selector bytes
// between a valid/ready producer and a valid/ready consumer.
module byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             push_c;
  logic             pop_c;

  // Handshake flags come only from registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign count     = cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_c, pop_c})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is never cleared; stale entries are masked by out_valid.
  always_ff @(posedge clk) begin
    if (rst_n && push_c) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_byte_fifo.sv
// Bench for byte_fifo: queue-based reference checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_byte_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  int n_cmp;
  int n_fail;
  bit check_en;

  logic [WIDTH-1:0] model_q [$];

  byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: an ordered queue with a DEPTH limit; reset empties it.
  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (!rst_n) begin
      model_q.delete();
    end else begin
      do_push = in_valid && (model_q.size() < DEPTH);
      do_pop  = out_ready && (model_q.size() != 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(in_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_count",     32'(count),     32'(model_q.size()));
      chk("cyc_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      chk("cyc_in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
      chk("cyc_out_data",  32'(out_data),  (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
    end
  end

  task automatic drive(input logic rst, input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    rst_n     = rst;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] drain_exp [4];
    logic [WIDTH-1:0] fill_vals [4];
    n_cmp    = 0;
    n_fail   = 0;
    check_en = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    out_ready = 1'b0;

    // Reset held two edges with a push request present
    drive(1'b0, 1'b1, 8'hAA, 1'b0);
    check_en = 1'b1;
    drive(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  32'(out_data),  32'h00);

    // Fill, then offer a byte that must be refused
    fill_vals[0] = 8'h01; fill_vals[1] = 8'h02; fill_vals[2] = 8'h05; fill_vals[3] = 8'h10;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, fill_vals[i], 1'b0);
    drive(1'b1, 1'b1, 8'hFF, 1'b0);
    chk("full_count",    32'(count),    32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head",     32'(out_data), 32'h01);

    // Drain in order
    drain_exp[0] = 8'h01; drain_exp[1] = 8'h02; drain_exp[2] = 8'h05; drain_exp[3] = 8'h10;
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 32'(out_data), 32'(drain_exp[i]));
      drive(1'b1, 1'b0, 8'h00, 1'b1);
    end
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_count",     32'(count),     32'd0);
    chk("drain_out_data",  32'(out_data),  32'h00);

    // Empty pop request: nothing happens
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    chk("empty_pop_count", 32'(count), 32'd0);

    // Full with simultaneous push and pop
    fill_vals[0] = 8'h11; fill_vals[1] = 8'h22; fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, fill_vals[i], 1'b0);
    drive(1'b1, 1'b1, 8'h08, 1'b1);
    chk("fullpp_count", 32'(count),    32'd3);
    chk("fullpp_head",  32'(out_data), 32'h22);
    drive(1'b1, 1'b1, 8'h08, 1'b0);
    chk("fullpp_retry_count", 32'(count), 32'd4);
    drain_exp[0] = 8'h22; drain_exp[1] = 8'h33; drain_exp[2] = 8'h44; drain_exp[3] = 8'h08;
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_drain", 32'(out_data), 32'(drain_exp[i]));
      drive(1'b1, 1'b0, 8'h00, 1'b1);
    end

    // Streaming through the wrap starting at one entry
    drive(1'b1, 1'b1, 8'hE0, 1'b1);
    chk("stream_start_count", 32'(count), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("stream_head", 32'(out_data), (i == 0) ? 32'hE0 : 32'(8'hF0 + 8'(i - 1)));
      drive(1'b1, 1'b1, 8'(8'hF0 + 8'(i)), 1'b1);
      chk("stream_count", 32'(count), 32'd1);
    end
    chk("stream_last", 32'(out_data), 32'hF9);

    // Reset mid-stream with push and pop requested
    drive(1'b1, 1'b1, 8'hA1, 1'b0);
    drive(1'b1, 1'b1, 8'hA2, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    drive(1'b0, 1'b1, 8'h77, 1'b1);
    chk("midrst_count",     32'(count),     32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 1'b1, 8'h5A, 1'b0);
    chk("post_rst_head",  32'(out_data), 32'h5A);
    chk("post_rst_count", 32'(count),    32'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    chk("final_count", 32'(count), 32'd0);

    @(negedge clk);
    check_en = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
